fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write-port arbiter sharing one syn_fifo write port among R producers.
//   Each producer has a valid/ready channel. The arbiter grants one producer at a time
//   for a burst of up to BURST beats. It drives syn_fifo write_en/data_in and obeys syn_fifo full.
//   Sits directly in front of syn_fifo; read side is untouched.
// PARAMETERS
//   N      8   data width; must match syn_fifo N
//   R      4   number of requesters, >=2
//   BURST  4   max beats per grant, >=1
// PORTS
//   clk            in   1          rising-edge clock, the only clock
//   reset          in   1          synchronous, active-high reset
//   req_valid      in   R          req_valid[i]: requester i has a beat on req_data
//   req_data       in   R*N        requester i data at bits [i*N +: N]
//   req_ready      out  R          req_ready[i]: beat of requester i accepted this cycle
//   fifo_full      in   1          from syn_fifo full
//   fifo_write_en  out  1          to syn_fifo write_en
//   fifo_data_in   out  N          to syn_fifo data_in
//   grant_id       out  clog2(R)   current owner index; valid while busy=1
//   busy           out  1          state==OWN
// BEHAVIOUR
//   Registered state: st{IDLE,OWN}, owner, ptr (next-priority index), beat_cnt [clog2(BURST+1)].
//   Reset (sync, sampled at posedge clk):
//     st=IDLE, owner=0, ptr=0, beat_cnt=0.
//     All outputs are 0 while reset=1 (req_ready, fifo_write_en, fifo_data_in, grant_id, busy).
//     Asserting reset mid-burst drops the grant. No write occurs in a reset cycle.
//   IDLE:
//     If any req_valid, owner <= first i with req_valid[i] scanning ptr, ptr+1, ..., wrapping mod R.
//     Then beat_cnt <= 0 and st <= OWN.
//     No beat is accepted in the IDLE cycle: 1-cycle arbitration latency.
//   OWN (combinational outputs):
//     xfer = req_valid[owner] & ~fifo_full.
//     fifo_write_en = xfer.
//     req_ready = xfer << owner; one-hot or zero, never more than one bit.
//     fifo_data_in = req_data[owner*N +: N] while busy, else 0.
//     Each xfer transfers exactly one beat into the FIFO in that same cycle.
//   OWN transitions (evaluated in priority order):
//     xfer & beat_cnt==BURST-1    -> IDLE, ptr <= (owner+1)%R   (burst limit)
//     xfer                        -> beat_cnt <= beat_cnt+1, stay OWN
//     ~req_valid[owner]           -> IDLE, ptr <= (owner+1)%R   (owner released)
//     req_valid[owner] & fifo_full -> stall: stay OWN, beat_cnt holds
//   Full handling:
//     fifo_write_en is never 1 while fifo_full=1.
//     syn_fifo wastes one location, so full asserts at M-1 entries; the arbiter trusts the flag.
//   Fairness:
//     A continuously-valid requester is granted within R-1 other grants.
//     Each of those grants lasts at most BURST beats plus 1 IDLE cycle, excluding full stalls.
//   Other rules:
//     A requester that deasserts valid mid-burst loses its grant; its next beat re-arbitrates.
//     Non-owner req_valid changes have no effect during OWN.
// TESTING
//   1 reset=1 for 2 clk with all req_valid=1 -> all outputs 0, no fifo write.
//   2 Only req 2 valid, data A0..A5, fifo_full=0 -> grant_id=2, beats A0..A3 written on
//     consecutive cycles; IDLE 1 cycle; regrant 2; A4,A5 written.
//   3 All 4 valid continuously, BURST=4 -> grant order 0,1,2,3,0.
//     Each grant gives exactly 4 writes followed by 1 idle cycle.
//   4 Req 1 owns; fifo_full=1 for 3 cycles after 2 beats -> fifo_write_en=0, req_ready=0,
//     beat_cnt stays 2; after full drops, 2 more beats, then release.
//   5 Req 0 owns, valid drops after 1 beat while req 3 is valid -> IDLE next cycle, grant 3.
//   6 reset pulsed mid-burst at beat 2 -> next cycle st=IDLE, ptr=0; re-arbitration starts at req 0.
//   All: end-to-end scoreboard on syn_fifo (M=16); no overflow; per-requester order preserved.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle for the producer channels and the syn_fifo write port seen by fifo_wr_arbiter.
// master is the arbiter side; slave is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int N = 8,
    parameter int R = 4
) ();
    localparam int RW = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_data;
    logic [R-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_write_en;
    logic [N-1:0]   fifo_data_in;
    logic [RW-1:0]  grant_id;
    logic           busy;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_write_en, fifo_data_in, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_write_en, fifo_data_in, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one syn_fifo write port among R valid/ready producers,
// granting one producer at a time for bursts of up to BURST beats.
module fifo_wr_arbiter #(
    parameter int N     = 8,
    parameter int R     = 4,
    parameter int BURST = 4,
    localparam int RW   = (R > 1) ? $clog2(R) : 1,
    localparam int BW   = (BURST > 0) ? $clog2(BURST + 1) : 1
) (
    input  logic                clk,
    input  logic                reset,
    fifo_wr_arbiter_if.master   bus,
    output logic                dbg_state_o,
    output logic [RW-1:0]       dbg_ptr_o,
    output logic [BW-1:0]       dbg_beat_cnt_o
);
    // Handshake: a beat of requester i moves when req_valid[i] & req_ready[i] on a
    // rising edge; req_ready never depends on non-owner valids and is low when full.
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} st_t;

    st_t           st_q, st_d;
    logic [RW-1:0] owner_q, owner_d;
    logic [RW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] cnt_q, cnt_d;

    logic          busy_w;
    logic          own_valid;
    logic [N-1:0]  own_data;
    logic          xfer;
    logic          pick_found;
    logic [RW-1:0] pick_idx;
    logic [RW:0]   cand_sum;
    logic [RW-1:0] cand;
    logic [RW-1:0] owner_nxt;

    always_comb begin
        own_valid = 1'b0;
        own_data  = '0;
        for (int i = 0; i < R; i++) begin
            if (owner_q == RW'(i)) begin
                own_valid = bus.req_valid[i];
                own_data  = bus.req_data[i*N +: N];
            end
        end
    end

    // Outputs are forced low during reset even if the register still says OWN.
    assign busy_w    = (st_q == OWN) && !reset;
    assign xfer      = busy_w && own_valid && !bus.fifo_full;
    assign owner_nxt = (owner_q == RW'(R - 1)) ? '0 : owner_q + RW'(1);

    assign bus.busy          = busy_w;
    assign bus.fifo_write_en = xfer;
    assign bus.req_ready     = xfer ? (R'(1) << owner_q) : '0;
    assign bus.fifo_data_in  = busy_w ? own_data : '0;
    assign bus.grant_id      = busy_w ? owner_q : '0;

    assign dbg_state_o    = (st_q == OWN);
    assign dbg_ptr_o      = ptr_q;
    assign dbg_beat_cnt_o = cnt_q;

    // Scan ptr, ptr+1, ... modulo R; the first valid requester wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand       = '0;
        for (int k = 0; k < R; k++) begin
            cand_sum = {1'b0, ptr_q} + (RW + 1)'(k);
            if (cand_sum >= (RW + 1)'(R)) begin
                cand_sum = cand_sum - (RW + 1)'(R);
            end
            cand = cand_sum[RW-1:0];
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (st_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    st_d    = OWN;
                end
            end
            OWN: begin
                if (xfer && (cnt_q == BW'(BURST - 1))) begin
                    st_d  = IDLE;
                    ptr_d = owner_nxt;
                end else if (xfer) begin
                    cnt_d = cnt_q + BW'(1);
                end else if (!own_valid) begin
                    st_d  = IDLE;
                    ptr_d = owner_nxt;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: cycle vectors with hand-computed outputs plus a
// scoreboard pairing each accepted producer beat with the FIFO write of that cycle.
module tb_fifo_wr_arbiter;
  localparam int N = 8;
  localparam int R = 4;
  localparam int BURST = 4;

  typedef struct packed {
    logic       rst;
    logic [3:0] vld;
    logic       full;
    logic       busy;
    logic [1:0] gid;
    logic       we;
    logic [3:0] rdy;
    logic [7:0] dat;
    logic       chk_sp;
    logic       st;
    logic [1:0] ptr;
    logic       chk_cnt;
    logic [2:0] cnt;
  } vec_t;

  logic clk;
  logic reset;
  logic dbg_state;
  logic [1:0] dbg_ptr;
  logic [2:0] dbg_cnt;

  fifo_wr_arbiter_if #(.N(N), .R(R)) bus ();

  fifo_wr_arbiter #(.N(N), .R(R), .BURST(BURST)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state),
    .dbg_ptr_o(dbg_ptr),
    .dbg_beat_cnt_o(dbg_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int vec_no = 0;
  logic [5:0] seq [4];
  logic [N-1:0] exp_q [$];
  vec_t tbl [$];

  function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic full,
                              input logic busy, input logic [1:0] gid, input logic we,
                              input logic [3:0] rdy, input logic [7:0] dat,
                              input logic chk_sp, input logic st, input logic [1:0] ptr,
                              input logic chk_cnt, input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.full = full;
    v.busy = busy; v.gid = gid; v.we = we; v.rdy = rdy; v.dat = dat;
    v.chk_sp = chk_sp; v.st = st; v.ptr = ptr;
    v.chk_cnt = chk_cnt; v.cnt = cnt;
    return v;
  endfunction

  // driver + checker for one clock cycle
  task automatic step(input vec_t v);
    logic [3:0] rdy_s;
    logic we_s;
    logic [N-1:0] got;
    logic [15:0] act_o;
    logic [15:0] exp_o;
    reset = v.rst;
    bus.req_valid = v.vld;
    bus.fifo_full = v.full;
    for (int i = 0; i < R; i++) bus.req_data[i*N +: N] = {2'(i), seq[i]};
    @(negedge clk);
    rdy_s = bus.req_ready;
    we_s = bus.fifo_write_en;
    n_cmp++;
    if ($countones(rdy_s) > 1 || ((rdy_s != 4'b0) != we_s)) begin
      n_err++;
      $display("FAIL ready_vs_we vec%0d: ready=%b write_en=%b, required one-hot ready iff write", vec_no, rdy_s, we_s);
    end
    n_cmp++;
    if (we_s && bus.fifo_full) begin
      n_err++;
      $display("FAIL write_when_full vec%0d: write_en=1 with fifo_full=1, required write_en=0", vec_no);
    end
    for (int i = 0; i < R; i++) if (rdy_s[i]) exp_q.push_back({2'(i), seq[i]});
    if (we_s) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty vec%0d: write of %h with no accepted beat", vec_no, bus.fifo_data_in);
      end else begin
        got = exp_q.pop_front();
        if (bus.fifo_data_in !== got) begin
          n_err++;
          $display("FAIL sb_data vec%0d: fifo_data_in=%h required %h", vec_no, bus.fifo_data_in, got);
        end
      end
    end
    act_o = {bus.busy, bus.grant_id, bus.fifo_write_en, bus.req_ready, bus.fifo_data_in};
    exp_o = {v.busy, v.gid, v.we, v.rdy, v.dat};
    n_cmp++;
    if (act_o !== exp_o) begin
      n_err++;
      $display("FAIL outputs vec%0d: {busy,gid,we,ready,data} got %h required %h", vec_no, act_o, exp_o);
    end
    if (v.chk_sp) begin
      n_cmp++;
      if ({dbg_state, dbg_ptr} !== {v.st, v.ptr}) begin
        n_err++;
        $display("FAIL state_ptr vec%0d: st=%b ptr=%0d required st=%b ptr=%0d", vec_no, dbg_state, dbg_ptr, v.st, v.ptr);
      end
    end
    if (v.chk_cnt) begin
      n_cmp++;
      if (dbg_cnt !== v.cnt) begin
        n_err++;
        $display("FAIL beat_cnt vec%0d: got %0d required %0d", vec_no, dbg_cnt, v.cnt);
      end
    end
    @(posedge clk);
    for (int i = 0; i < R; i++) if (rdy_s[i]) seq[i] = seq[i] + 6'd1;
    #1;
    vec_no++;
  endtask

  initial begin : main
    logic [5:0] e [4];
    int id;
    for (int i = 0; i < R; i++) seq[i] = 6'd0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;

    // reset with all valid high: outputs zero, registers cleared
    tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 0, 1, 0));
    // only requester 2: burst of 4, one idle cycle, regrant, release
    tbl.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 1, 4'b0100, 8'h80, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 1, 4'b0100, 8'h81, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 1, 4'b0100, 8'h82, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 1, 4'b0100, 8'h83, 1, 1, 0, 1, 3));
    tbl.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 3, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 1, 4'b0100, 8'h84, 1, 1, 3, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 1, 4'b0100, 8'h85, 1, 1, 3, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 2, 0, 4'b0000, 8'h86, 1, 1, 3, 1, 2));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 3, 0, 0));
    // requester 1 with a 3-cycle full stall after 2 beats
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 1, 1, 1, 4'b0010, 8'h40, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 1, 1, 1, 4'b0010, 8'h41, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0010, 1, 1, 1, 0, 4'b0000, 8'h42, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 4'b0010, 1, 1, 1, 0, 4'b0000, 8'h42, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 4'b0010, 1, 1, 1, 0, 4'b0000, 8'h42, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 4'b0010, 0, 1, 1, 1, 4'b0010, 8'h42, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 4'b0010, 0, 1, 1, 1, 4'b0010, 8'h43, 1, 1, 0, 1, 3));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 2, 0, 0));
    // requester 0 drops valid after 1 beat while requester 3 waits
    tbl.push_back(mk(1, 4'b1001, 0, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1001, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1001, 0, 1, 0, 1, 4'b0001, 8'h00, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 1, 0, 0, 4'b0000, 8'h01, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 1, 3, 1, 4'b1000, 8'hC0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 3, 0, 4'b0000, 8'hC1, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // all four continuously valid: grants 0,1,2,3,0, each 4 writes + 1 idle cycle
    e[0] = 6'd1; e[1] = 6'd4; e[2] = 6'd6; e[3] = 6'd1;
    step(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0));
    for (int g = 0; g < 5; g++) begin
      id = g % R;
      step(mk(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 2'(id), 0, 0));
      for (int b = 0; b < BURST; b++) begin
        step(mk(0, 4'b1111, 0, 1, 2'(id), 1, 4'(1 << id), {2'(id), e[id]}, 1, 1, 2'(id), 1, 3'(b)));
        e[id] = e[id] + 6'd1;
      end
    end
    step(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 1, 0, 0));

    // reset mid-burst at beat 2 drops the grant; re-arbitration scans from 0
    step(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0));
    step(mk(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 0, 0, 0));
    step(mk(0, 4'b0100, 0, 1, 2, 1, 4'b0100, 8'h8A, 1, 1, 0, 1, 0));
    step(mk(0, 4'b0100, 0, 1, 2, 1, 4'b0100, 8'h8B, 1, 1, 0, 1, 1));
    step(mk(1, 4'b0101, 0, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0));
    step(mk(0, 4'b0101, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 0, 0, 0));
    step(mk(0, 4'b0101, 0, 1, 0, 1, 4'b0001, 8'h09, 1, 1, 0, 1, 0));
    step(mk(0, 4'b0000, 0, 1, 0, 0, 4'b0000, 8'h0A, 1, 1, 0, 1, 1));
    step(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 1, 0, 0));

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d accepted beats never written, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
